masked_cubic_layer: RTL



---
 rtl/masked_cubic_pkg.sv | 40 ++++
 rtl/masked_cubic_comp.sv | 84 ++++++++
 rtl/masked_cubic_layer.sv | 65 ++++++
 3 files changed

// File: rtl/masked_cubic_pkg.sv
// Shared constants and index helpers for the 3-share masked cubic S-box layer.
// Component groups are laid out F0, F1 (27 each) then F2, F3 (9 each) per channel.
package masked_cubic_pkg;

    localparam int SHARES       = 3;
    localparam int NUM_FUNC     = 4;
    localparam int RND_PER_SBOX = 84;
    localparam int NCOMP_CUBIC  = 27;
    localparam int NCOMP_QUAD   = 9;
    localparam int NCOMP_TOTAL  = 2 * NCOMP_CUBIC + 2 * NCOMP_QUAD;
    localparam int OUT_PER_SBOX = NUM_FUNC * SHARES;
    localparam int DR_BITS      = NUM_FUNC * SHARES;

    // Randomness field offsets within one channel's 84-bit slice
    localparam int R0_OFF = 0;
    localparam int R1_OFF = R0_OFF + NCOMP_CUBIC;
    localparam int R2_OFF = R1_OFF + NCOMP_CUBIC;
    localparam int R3_OFF = R2_OFF + NCOMP_QUAD;
    localparam int DR_OFF = R3_OFF + NCOMP_QUAD;

    // d-share index paired with (b_i, a_j, c_l) in a cubic component
    function automatic int d_index(input int i, input int j, input int l);
        return (i - j + l + SHARES) % SHARES;
    endfunction

    function automatic int comp_offset(input int f);
        case (f)
            0:       return 0;
            1:       return NCOMP_CUBIC;
            2:       return 2 * NCOMP_CUBIC;
            default: return 2 * NCOMP_CUBIC + NCOMP_QUAD;
        endcase
    endfunction

    // Number of components that share one leading index i (feed one output share)
    function automatic int comp_group(input int f);
        return (f < 2) ? NCOMP_CUBIC / SHARES : NCOMP_QUAD / SHARES;
    endfunction

endpackage

// File: rtl/masked_cubic_comp.sv
// Combinational share-component generation for one S-box channel.
// Each share-monomial lands in the lowest-numbered component containing its shares.
module masked_cubic_comp
    import masked_cubic_pkg::*;
(
    input  logic [SHARES-1:0]       a_sh,
    input  logic [SHARES-1:0]       b_sh,
    input  logic [SHARES-1:0]       c_sh,
    input  logic [SHARES-1:0]       d_sh,
    input  logic [RND_PER_SBOX-1:0] rnd,
    output logic [NCOMP_TOTAL-1:0]  comp
);

    logic [NCOMP_CUBIC-1:0] r0;
    logic [NCOMP_CUBIC-1:0] r1;
    logic [NCOMP_QUAD-1:0]  r2;
    logic [NCOMP_QUAD-1:0]  r3;
    logic [DR_BITS-1:0]     dr;

    assign r0 = rnd[R0_OFF +: NCOMP_CUBIC];
    assign r1 = rnd[R1_OFF +: NCOMP_CUBIC];
    assign r2 = rnd[R2_OFF +: NCOMP_QUAD];
    assign r3 = rnd[R3_OFF +: NCOMP_QUAD];
    assign dr = rnd[DR_OFF +: DR_BITS];

    // dr bits are chained share-to-share in a ring so they cancel in the unmasked sum
    for (genvar i = 0; i < SHARES; i++) begin : g_ci
        for (genvar j = 0; j < SHARES; j++) begin : g_cj
            for (genvar l = 0; l < SHARES; l++) begin : g_cl
                localparam int N  = 9 * i + 3 * j + l;
                localparam int M  = d_index(i, j, l);
                localparam int NX = (N + 1) % NCOMP_CUBIC;
                localparam int IX = (i + 1) % SHARES;

                logic ab;
                logic bcd;
                assign ab  = a_sh[j] & b_sh[i];
                assign bcd = b_sh[i] & c_sh[l] & d_sh[M];

                assign comp[comp_offset(0) + N] = (ab & c_sh[l]) ^ bcd
                    ^ ((l == 0) ? ab : 1'b0)
                    ^ ((i == 0) ? ((a_sh[j] & c_sh[l]) ^ (a_sh[j] & d_sh[M])) : 1'b0)
                    ^ ((j == 0) ? (b_sh[i] & d_sh[M]) : 1'b0)
                    ^ ((i == 0 && l == 0) ? a_sh[j] : 1'b0)
                    ^ ((j == 0 && l == 0) ? b_sh[i] : 1'b0)
                    ^ ((i == 0 && j == 0) ? (c_sh[l] ^ d_sh[M]) : 1'b0)
                    ^ r0[N] ^ r0[NX]
                    ^ ((j == 0 && l == 0) ? (dr[4 * i] ^ dr[4 * IX]) : 1'b0);

                assign comp[comp_offset(1) + N] = bcd
                    ^ ((l == 0) ? ab : 1'b0)
                    ^ ((j == 0) ? ((b_sh[i] & c_sh[l]) ^ (b_sh[i] & d_sh[M])) : 1'b0)
                    ^ ((i == 0) ? (c_sh[l] & d_sh[M]) : 1'b0)
                    ^ ((i == 0 && l == 0) ? a_sh[j] : 1'b0)
                    ^ ((i == 0 && j == 0) ? d_sh[M] : 1'b0)
                    ^ r1[N] ^ r1[NX]
                    ^ ((j == 0 && l == 0) ? (dr[4 * i + 1] ^ dr[4 * IX + 1]) : 1'b0);
            end
        end
    end

    for (genvar i = 0; i < SHARES; i++) begin : g_qi
        for (genvar j = 0; j < SHARES; j++) begin : g_qj
            localparam int N  = 3 * i + j;
            localparam int NX = (N + 1) % NCOMP_QUAD;
            localparam int IX = (i + 1) % SHARES;

            assign comp[comp_offset(2) + N] = (b_sh[i] & c_sh[j])
                ^ ((j == 0) ? (b_sh[i] ^ d_sh[i]) : 1'b0)
                ^ ((i == 0) ? c_sh[j] : 1'b0)
                ^ ((N == 0) ? 1'b1 : 1'b0)
                ^ r2[N] ^ r2[NX]
                ^ ((j == 0) ? (dr[4 * i + 2] ^ dr[4 * IX + 2]) : 1'b0);

            assign comp[comp_offset(3) + N] = (c_sh[i] & d_sh[j])
                ^ ((j == 0) ? (c_sh[i] ^ a_sh[i]) : 1'b0)
                ^ ((i == 0) ? d_sh[j] : 1'b0)
                ^ ((N == 0) ? 1'b1 : 1'b0)
                ^ r3[N] ^ r3[NX]
                ^ ((j == 0) ? (dr[4 * i + 3] ^ dr[4 * IX + 3]) : 1'b0);
        end
    end

endmodule

// File: rtl/masked_cubic_layer.sv
// Two-stage masked cubic S-box layer: registered components, then registered
// per-share compression, with valid tracking and a global stall enable.
module masked_cubic_layer
    import masked_cubic_pkg::*;
#(
    parameter int NUM_SBOX = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             in_valid,
    input  logic [SHARES*NUM_SBOX-1:0]       a_sh,
    input  logic [SHARES*NUM_SBOX-1:0]       b_sh,
    input  logic [SHARES*NUM_SBOX-1:0]       c_sh,
    input  logic [SHARES*NUM_SBOX-1:0]       d_sh,
    input  logic [RND_PER_SBOX*NUM_SBOX-1:0] rnd,
    output logic                             out_valid,
    output logic [OUT_PER_SBOX*NUM_SBOX-1:0] f_sh
);

    logic [NCOMP_TOTAL*NUM_SBOX-1:0]  comp_d;
    logic [NCOMP_TOTAL*NUM_SBOX-1:0]  comp_q;
    logic [OUT_PER_SBOX*NUM_SBOX-1:0] f_d;
    logic [OUT_PER_SBOX*NUM_SBOX-1:0] f_q;
    logic                             v1;
    logic                             v2;

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_ch
        masked_cubic_comp u_comp (
            .a_sh (a_sh[SHARES*k +: SHARES]),
            .b_sh (b_sh[SHARES*k +: SHARES]),
            .c_sh (c_sh[SHARES*k +: SHARES]),
            .d_sh (d_sh[SHARES*k +: SHARES]),
            .rnd  (rnd[RND_PER_SBOX*k +: RND_PER_SBOX]),
            .comp (comp_d[NCOMP_TOTAL*k +: NCOMP_TOTAL])
        );

        // Output share s folds the contiguous run of components whose leading index is s
        for (genvar f = 0; f < NUM_FUNC; f++) begin : g_fn
            localparam int G = comp_group(f);
            for (genvar s = 0; s < SHARES; s++) begin : g_sh
                assign f_d[OUT_PER_SBOX*k + SHARES*f + s] =
                    ^comp_q[NCOMP_TOTAL*k + comp_offset(f) + G*s +: G];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_q <= '0;
            f_q    <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
        end else if (en) begin
            comp_q <= comp_d;
            f_q    <= f_d;
            v1     <= in_valid;
            v2     <= v1;
        end
    end

    assign f_sh      = f_q;
    assign out_valid = v2;

endmodule
